// File: rtl/sdhci_rsp_pkg.sv
// Shared states, frame lengths and the CRC7 step for the SD CMD-line response path.
package sdhci_rsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RECEIVE,
    ST_DONE
  } rsp_state_e;

  localparam int unsigned RspShortLen = 48;
  localparam int unsigned RspLongLen  = 136;
  localparam logic [6:0]  Crc7Poly    = 7'h09;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic dat);
    logic fb;
    fb = dat ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
  endfunction

endpackage

// File: rtl/sdhci_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per enabled cycle; clear takes effect in the same cycle
// as an enabled bit so a frame can be seeded and fed at once. No backpressure.
module sdhci_crc7
  import sdhci_rsp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       dat_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d, base;

  always_comb begin
    base  = clr_i ? 7'h00 : crc_q;
    crc_d = base;
    if (en_i) crc_d = crc7_step(base, dat_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 7'h00;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sdhci_rsp_receiver.sv
// SD CMD-line response receiver: hunts the start bit within Ncr, deserialises 48/136-bit frames.
// done_o one cycle after the end bit; the card cannot be stalled, so there is no backpressure.
module sdhci_rsp_receiver
  import sdhci_rsp_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         long_i,
  input  logic         check_crc_i,
  input  logic         check_index_i,
  input  logic [5:0]   expected_index_i,
  input  logic         sd_cmd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] rsp_o,
  output logic [5:0]   index_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  localparam int unsigned WaitW   = $clog2(TimeoutCycles + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TimeoutCycles);
  localparam logic [7:0] ShortLen     = 8'(RspShortLen);
  localparam logic [7:0] LongLen      = 8'(RspLongLen);
  localparam logic [7:0] ShortCrcLast = 8'(RspShortLen - 8);
  localparam logic [7:0] LongCrcFirst = 8'(RspLongLen - 127);
  localparam logic [7:0] LongCrcLast  = 8'(RspLongLen - 8);

  rsp_state_e       state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       bitcnt_q, bitcnt_d, bit_num, frame_len;
  // sr_q[k] holds frame bit k+1 once the end bit arrives; the start/transmission bits fall off.
  logic [132:0]     sr_q, sr_d;
  logic             long_q, long_d, chk_crc_q, chk_crc_d, chk_idx_q, chk_idx_d;
  logic [5:0]       exp_idx_q, exp_idx_d, index_q, index_d;
  logic [119:0]     rsp_q, rsp_d;
  logic             tmo_q, tmo_d, crc_err_q, crc_err_d, end_err_q, end_err_d, idx_err_q, idx_err_d;
  logic             crc_clr, crc_en;
  logic [6:0]       crc_val;

  sdhci_crc7 u_crc7 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .dat_i  (sd_cmd_i),
    .crc_o  (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    long_d    = long_q;
    chk_crc_d = chk_crc_q;
    chk_idx_d = chk_idx_q;
    exp_idx_d = exp_idx_q;
    rsp_d     = rsp_q;
    index_d   = index_q;
    tmo_d     = tmo_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    idx_err_d = idx_err_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    bit_num   = bitcnt_q + 8'd1;
    frame_len = long_q ? LongLen : ShortLen;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          long_d    = long_i;
          chk_crc_d = check_crc_i;
          chk_idx_d = check_index_i;
          exp_idx_d = expected_index_i;
          tmo_d     = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          idx_err_d = 1'b0;
          wait_d    = '0;
          crc_clr   = 1'b1;
          state_d   = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (!sd_cmd_i) begin
          bitcnt_d = 8'd1;
          sr_d     = {sr_q[131:0], 1'b0};
          crc_en   = !long_q;
          state_d  = ST_RECEIVE;
        end else begin
          wait_d = wait_q + WaitW'(1);
          if (wait_d == WaitMax) begin
            tmo_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RECEIVE: begin
        bitcnt_d = bit_num;
        crc_en   = long_q ? (bit_num >= LongCrcFirst && bit_num <= LongCrcLast)
                          : (bit_num <= ShortCrcLast);
        if (bit_num == frame_len) begin
          end_err_d = !sd_cmd_i;
          crc_err_d = chk_crc_q && (crc_val != sr_q[6:0]);
          idx_err_d = chk_idx_q && !long_q && (sr_q[44:39] != exp_idx_q);
          rsp_d     = long_q ? sr_q[126:7] : {88'h0, sr_q[38:7]};
          index_d   = long_q ? sr_q[132:127] : sr_q[44:39];
          state_d   = ST_DONE;
        end else begin
          sr_d = {sr_q[131:0], sd_cmd_i};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      bitcnt_q  <= 8'd0;
      sr_q      <= '0;
      long_q    <= 1'b0;
      chk_crc_q <= 1'b0;
      chk_idx_q <= 1'b0;
      exp_idx_q <= 6'd0;
      rsp_q     <= '0;
      index_q   <= 6'd0;
      tmo_q     <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      long_q    <= long_d;
      chk_crc_q <= chk_crc_d;
      chk_idx_q <= chk_idx_d;
      exp_idx_q <= exp_idx_d;
      rsp_q     <= rsp_d;
      index_q   <= index_d;
      tmo_q     <= tmo_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign busy_o        = (state_q == ST_WAIT_START) || (state_q == ST_RECEIVE);
  assign done_o        = (state_q == ST_DONE);
  assign rsp_o         = rsp_q;
  assign index_o       = index_q;
  assign timeout_err_o = tmo_q;
  assign crc_err_o     = crc_err_q;
  assign end_bit_err_o = end_err_q;
  assign index_err_o   = idx_err_q;

endmodule

// File: doc/sdhci_rsp_receiver.md
# sdhci_rsp_receiver

Host-side receiver for SD command responses on the CMD line, inside the SDHCI controller's SD-clock datapath. The command issuer arms it after the last command bit. It then hunts for the card's start bit within the Ncr window and deserialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response. On completion it reports the payload and the timeout, CRC, end-bit and index error flags for the Error Interrupt Status register.

## Interface
- `TimeoutCycles`, default 64: SD-clock cycles allowed between arm and start bit (Ncr max).
- `clk_i` in 1: SD clock; `sd_cmd_i` sampled on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: single-cycle arm pulse; ignored while `busy_o`.
- `long_i` in 1: 1 = 136-bit response, 0 = 48-bit; captured with `start_i`.
- `check_crc_i` in 1: enable CRC7 check; captured with `start_i`.
- `check_index_i` in 1: enable index check (48-bit only); captured with `start_i`.
- `expected_index_i` in 6: command index to compare; captured with `start_i`.
- `sd_cmd_i` in 1: CMD line as seen by host.
- `busy_o` out 1: high from cycle after arm until `done_o`.
- `done_o` out 1: one-cycle completion pulse.
- `rsp_o` out 120: short responses use [31:0] = card status/argument and [119:32] = 0; long responses use [119:0] = R[127:8].
- `index_o` out 6: received index field.
- `timeout_err_o`, `crc_err_o`, `end_bit_err_o`, `index_err_o` out 1 each: valid when `done_o`, held until next arm.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE, `start_i`: latch config, clear error flags and wait counter, go to WAIT_START.
- WAIT_START, `sd_cmd_i`=0: this is the start bit. Go to RECEIVE with bit count 1 and the CRC seeded over the start bit.
- WAIT_START, `sd_cmd_i`=1: wait counter +1. When the counter reaches `TimeoutCycles`, set `timeout_err_o` and go to DONE. `rsp_o` and `index_o` are left unchanged.
- RECEIVE: shift one bit per cycle MSB-first until 48 or 136 bits total, including start and end.
- CRC7 polynomial is x^7+x^3+1 with seed 0.
  - Short response: covers bits 47..8 (start, transmission, index, 32-bit payload).
  - Long response: covers bits 127..8 only; start, transmission and the six check bits are excluded.
  - Compared against received bits 7..1.
- On the end-bit cycle:
  - `end_bit_err_o` = end bit is 0.
  - `crc_err_o` = `check_crc_i` and mismatch.
  - `index_err_o` = `check_index_i` and not long and index differs from `expected_index_i`.
  - Commit `rsp_o` and `index_o`, then go to DONE.
- The transmission bit is not checked separately; a wrong transmission bit surfaces only through CRC.
- DONE: assert `done_o` for one cycle, then go to IDLE.
- Width rules: wait counter is `$clog2(TimeoutCycles+1)` bits; bit counter is 8 bits.

## Timing
- Reset values: all outputs 0; state IDLE; shift register and CRC cleared.
- `start_i` at cycle t: the first possible start-bit sample is t+1.
- Start bit sampled at cycle k:
  - End bit at k+47 (short) or k+135 (long).
  - `done_o` at k+48 or k+136.
- Timeout: `sd_cmd_i` high for `TimeoutCycles` consecutive samples starting at t+1 gives `done_o` at t+`TimeoutCycles`+1.
- A start bit seen on the last allowed sample is accepted, not timed out.
- `busy_o` falls in the same cycle `done_o` is high. A `start_i` in the `done_o` cycle is ignored; a `start_i` in the following cycle is accepted.
- Reset mid-frame: immediate return to IDLE with no `done_o`; partial data is discarded.

## Structure
- Package `sdhci_rsp_pkg`: state enum, `RspShortLen`=48, `RspLongLen`=136, `Crc7Poly`=7'h09.
- Sub-module `sdhci_crc7`: serial CRC7 with clear, enable and data-bit inputs and a 7-bit CRC output. It is reusable by the command transmitter.

## Test plan
- **Short R1:** arm with index 17, check_crc=1, check_index=1. Drive 3 idle-high cycles, then frame {0,0,6'd17,32'h0000_0900,golden CRC,1}. Expect `done_o` 48 cycles after start, `rsp_o`[31:0]=32'h0000_0900, `index_o`=17, all error flags 0.
- **R3 path:** arm with check_crc=0, check_index=0. Drive frame with index 6'h3F, payload 32'h80FF_8000, CRC 7'h7F, end 1. Expect no errors and `rsp_o`[31:0]=32'h80FF_8000.
- **Long R2:** arm with long_i=1. Drive 127-bit CID with golden CRC7 in the low 7 bits. Expect `done_o` 136 cycles after start, `rsp_o`=R[127:8], no errors. Flip one CID bit and expect `crc_err_o`=1.
- **Timeout:** arm and hold `sd_cmd_i` high. Expect `done_o` with `timeout_err_o`=1 exactly 65 cycles after `start_i` and `rsp_o` unchanged. Start bit at the 64th sample is accepted.
- **Field errors:** expect index 8, send index 9, and end bit 0. Expect `index_err_o`=1 and `end_bit_err_o`=1 with `crc_err_o`=0.
- **Reset mid-frame:** assert `rst_ni` low at bit 20, release, and send a new armed frame. Expect all outputs 0 during reset, no spurious `done_o`, and a correct second response.
